mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_defs.sv | 45 ++++
 rtl/mdu_step.sv | 44 ++++
 rtl/mdu_iter.sv | 145 ++++++++++++++
 tb/tb_mdu_iter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// Shared constants, encodings and helpers for the iterative multiply/divide unit.
package mdu_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = $clog2(ITERS);
  localparam int unsigned OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Op needs the iterative datapath.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Op treats its operands as two's complement.
  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Op is a division.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring divide.
module mdu_step
  import mdu_defs::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);

  logic [XLEN:0]   x;
  logic [XLEN+1:0] addend;
  logic [XLEN+1:0] sum;

  // Shared adder: multiply adds b when lo[0] is set, divide trial-subtracts b.
  always_comb begin
    x      = '0;
    addend = '0;
    sum    = '0;
    hi_n   = hi;
    lo_n   = lo;
    if (is_div) begin
      x      = {hi, lo[XLEN-1]};
      addend = ~{2'b00, b};
      sum    = {1'b0, x} + addend + (XLEN+2)'(1);
      if (!sum[XLEN+1]) begin
        hi_n = sum[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = x[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      x      = {1'b0, hi};
      addend = lo[0] ? {2'b00, b} : '0;
      sum    = {1'b0, x} + addend;
      hi_n   = sum[XLEN:1];
      lo_n   = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
module mdu_iter
  import mdu_defs::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  state_e          state_q, state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            neg_a_q, neg_b_q;
  logic [XLEN-1:0] wk_hi_q, wk_lo_q;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            busy_q, done_q;

  logic            idle_like, start_md, start_mt, sgn_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] prod, prod_neg;
  hilo_t           fix;

  // Request decode and operand magnitudes for a new operation.
  always_comb begin
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    start_md  = idle_like && i_start && is_muldiv(i_op);
    start_mt  = idle_like && i_start && ((i_op == OP_MTHI) || (i_op == OP_MTLO));
    sgn_in    = is_signed_op(i_op);
    a_mag     = (sgn_in && i_a[XLEN-1]) ? -i_a : i_a;
    b_mag     = (sgn_in && i_b[XLEN-1]) ? -i_b : i_b;
  end

  mdu_step u_step (
    .is_div (is_div_op(op_q)),
    .hi     (wk_hi_q),
    .lo     (wk_lo_q),
    .b      (b_q),
    .hi_n   (step_hi),
    .lo_n   (step_lo)
  );

  // Next-state logic; flush wins over everything while busy.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: if (start_md) state_n = S_RUN;
      S_RUN: begin
        if (i_flush)            state_n = S_IDLE;
        else if (cnt_q == '0)   state_n = S_FIX;
      end
      S_FIX:  state_n = i_flush ? S_IDLE : S_DONE;
      S_DONE: state_n = start_md ? S_RUN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register, iteration counter and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n == S_RUN) || (state_n == S_FIX);
      done_q  <= (state_n == S_DONE);
      if (start_md)
        cnt_q <= CNT_W'(ITERS - 1);
      else if ((state_q == S_RUN) && (cnt_q != '0))
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Operand latch and working accumulator advanced once per RUN cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      wk_hi_q <= '0;
      wk_lo_q <= '0;
    end else if (start_md) begin
      op_q    <= i_op;
      a_q     <= i_a;
      b_q     <= b_mag;
      neg_a_q <= sgn_in && i_a[XLEN-1];
      neg_b_q <= sgn_in && i_b[XLEN-1];
      wk_hi_q <= '0;
      wk_lo_q <= a_mag;
    end else if (state_q == S_RUN) begin
      wk_hi_q <= step_hi;
      wk_lo_q <= step_lo;
    end
  end

  // Sign correction and divide-by-zero result selection.
  always_comb begin
    prod     = {wk_hi_q, wk_lo_q};
    prod_neg = -prod;
    fix.hi   = wk_hi_q;
    fix.lo   = wk_lo_q;
    if (!is_div_op(op_q)) begin
      if (neg_a_q ^ neg_b_q) fix = hilo_t'(prod_neg);
    end else if (b_q == '0) begin
      fix.hi = a_q;
      fix.lo = '1;
    end else begin
      if (neg_a_q ^ neg_b_q) fix.lo = -wk_lo_q;
      if (neg_a_q)           fix.hi = -wk_hi_q;
    end
  end

  // HI/LO: written by FIX (unless flushed) or directly by MTHI/MTLO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if ((state_q == S_FIX) && !i_flush) begin
      hi_q <= fix.hi;
      lo_q <= fix.lo;
    end else if (start_mt) begin
      if (i_op == OP_MTHI) hi_q <= i_a;
      else                 lo_q <= i_a;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter with hand-computed HI/LO results.
module tb_mdu_iter;
  import mdu_defs::*;

  logic        clk;
  logic        i_rst_n;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int nvec = 0;
  int nmis = 0;

  mdu_iter dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_flush (i_flush),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one edge; returns 1ns after that edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Entered 1ns after the start edge; checks 33 busy cycles, then done with results.
  task automatic watch(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                       input bit poke, input bit chain,
                       input logic [2:0] cop, input logic [31:0] ca, input logic [31:0] cb);
    int busy_n;
    bit early;
    busy_n = 0;
    early  = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (k <= 33) begin
        busy_n += int'(o_busy);
        early  |= o_done;
      end else begin
        check({tag, " done"}, 64'(o_done), 64'd1);
        check({tag, " busy_end"}, 64'(o_busy), 64'd0);
        check({tag, " hi"}, 64'(o_hi), 64'(ehi));
        check({tag, " lo"}, 64'(o_lo), 64'(elo));
      end
      if (poke && k == 5) begin
        i_start = 1'b1; i_op = OP_MTHI; i_a = 32'hDEAD_BEEF;
      end
      if (k < 34) begin
        tick();
        i_start = 1'b0;
      end
    end
    check({tag, " busy33"}, 64'(busy_n), 64'd33);
    check({tag, " early_done"}, 64'(early), 64'd0);
    if (chain) begin
      i_op = cop; i_a = ca; i_b = cb; i_start = 1'b1;
    end
    tick();
    i_start = 1'b0;
    if (!chain) check({tag, " pulse"}, 64'({o_busy, o_done}), 64'd0);
  endtask

  initial begin
    int done_n;
    i_rst_n = 1'b0; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0; i_flush = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    check("rst hi",   64'(o_hi),   64'd0);
    check("rst lo",   64'(o_lo),   64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    check("rst done", 64'(o_done), 64'd0);

    start_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    watch("mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, '0, '0, '0);
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    watch("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, '0, '0, '0);
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    watch("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, '0, '0, '0);
    start_op(OP_DIVU, 32'd7, 32'd0);
    watch("divu_by0", 32'd7, 32'hFFFF_FFFF, 0, 0, '0, '0, '0);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    watch("div_ovf", 32'd0, 32'h8000_0000, 0, 0, '0, '0, '0);
    start_op(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    watch("div_100_m7", 32'd2, 32'hFFFF_FFF2, 0, 0, '0, '0, '0);
    start_op(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    watch("div_m5_by0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 0, '0, '0, '0);
    start_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
    watch("mult_big", 32'hC000_0000, 32'h8000_0000, 0, 0, '0, '0, '0);

    // Start request at T+5 while busy must be ignored.
    start_op(OP_MULTU, 32'd3, 32'd4);
    watch("ignore_start", 32'd0, 32'd12, 1, 0, '0, '0, '0);

    // Flush at T+10 with a simultaneous start; HI/LO must keep 0/12.
    start_op(OP_MULTU, 32'd5, 32'd6);
    repeat (9) tick();
    i_flush = 1'b1; i_start = 1'b1; i_op = OP_DIV; i_a = 32'd9; i_b = 32'd3;
    tick();
    i_flush = 1'b0; i_start = 1'b0;
    check("flush busy", 64'(o_busy), 64'd0);
    check("flush done", 64'(o_done), 64'd0);
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      done_n += int'(o_done);
      tick();
    end
    check("flush no_done", 64'(done_n), 64'd0);
    check("flush hi", 64'(o_hi), 64'd0);
    check("flush lo", 64'(o_lo), 64'd12);

    // Direct HI/LO writes.
    start_op(OP_MTLO, 32'hA5A5_A5A5, 32'd0);
    check("mtlo lo", 64'(o_lo), 64'hA5A5_A5A5);
    check("mtlo hi", 64'(o_hi), 64'd0);
    check("mtlo busy", 64'(o_busy), 64'd0);
    start_op(OP_MTHI, 32'h1234_5678, 32'd0);
    check("mthi hi", 64'(o_hi), 64'h1234_5678);
    check("mthi lo", 64'(o_lo), 64'hA5A5_A5A5);
    tick();
    check("mthi quiet", 64'({o_busy, o_done}), 64'd0);

    // Back-to-back: DIV started in the DONE cycle of DIVU.
    start_op(OP_DIVU, 32'd100, 32'd7);
    watch("b2b_first", 32'd2, 32'd14, 0, 1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    watch("b2b_second", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, '0, '0, '0);

    // Undefined op is ignored.
    start_op(3'd6, 32'h1111_1111, 32'd1);
    check("undef busy", 64'(o_busy), 64'd0);
    check("undef hilo", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    tick();
    check("undef done", 64'(o_done), 64'd0);

    // Asynchronous reset in the middle of RUN.
    start_op(OP_MULT, 32'h0000_1234, 32'h0000_0010);
    repeat (5) tick();
    #2 i_rst_n = 1'b0;
    #1;
    check("arst hi",   64'(o_hi),   64'd0);
    check("arst lo",   64'(o_lo),   64'd0);
    check("arst busy", 64'(o_busy), 64'd0);
    check("arst done", 64'(o_done), 64'd0);
    tick(); tick();
    i_rst_n = 1'b1;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      done_n += int'(o_done) + int'(o_busy);
      tick();
    end
    check("arst no_done", 64'(done_n), 64'd0);

    start_op(OP_MULTU, 32'd5, 32'd6);
    watch("post_rst", 32'd0, 32'd30, 0, 0, '0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
